// File: rtl/dispatch_pkg.sv
// Shared types for the write-back demux dispatcher: FSM state encoding and error codes.
package dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_DISABLED = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

endpackage

// File: rtl/demux_dispatch_ctrl_demux4.sv
// DeMux4: routes one data word to one of four outputs; unselected outputs are driven to zero.
module DeMux4 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            sel,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic [DATA_WIDTH-1:0] dout2,
    output logic [DATA_WIDTH-1:0] dout3
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        dout0 = '0;
        dout1 = '0;
        dout2 = '0;
        dout3 = '0;
        case (sel)
            2'd0:    dout0 = din;
            2'd1:    dout1 = din;
            2'd2:    dout2 = din;
            default: dout3 = din;
        endcase
    end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Write-back dispatch sequencer: accepts a word + destination, drives the 4-way demux and
// waits (bounded) for the destination to accept, reporting done/error and a transfer count.
module demux_dispatch_ctrl
    import dispatch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_dest_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    input  logic [3:0]            dest_en_i,
    output logic [3:0]            dst_valid_o,
    input  logic [3:0]            dst_ready_i,
    output logic [DATA_WIDTH-1:0] dst_data0_o,
    output logic [DATA_WIDTH-1:0] dst_data1_o,
    output logic [DATA_WIDTH-1:0] dst_data2_o,
    output logic [DATA_WIDTH-1:0] dst_data3_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [1:0]            err_code_o,
    output logic [15:0]           xfer_count_o
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t                state, state_d;
    logic [1:0]            dest_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CW-1:0]         cnt_q;
    logic [1:0]            err_code_q;
    logic [15:0]           xfer_count_q;

    logic                  accept;
    logic                  dest_enabled;
    logic                  dst_hit;
    logic                  timed_out;
    logic [DATA_WIDTH-1:0] demux_din;

    assign accept       = req_valid_i && (state == IDLE);
    assign dest_enabled = dest_en_i[req_dest_i];
    assign dst_hit      = dst_ready_i[dest_q];
    assign timed_out    = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = dest_enabled ? SEND : ERR;
            SEND: begin
                // Ready on the last allowed cycle takes priority over the timeout.
                if (dst_hit)        state_d = DONE;
                else if (timed_out) state_d = ERR;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset_i) state <= IDLE;
        else         state <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dest_q       <= '0;
            data_q       <= '0;
            cnt_q        <= '0;
            err_code_q   <= ERR_NONE;
            xfer_count_q <= '0;
        end else begin
            if (accept) begin
                dest_q     <= req_dest_i;
                data_q     <= req_data_i;
                cnt_q      <= '0;
                err_code_q <= dest_enabled ? ERR_NONE : ERR_DISABLED;
            end
            if (state == SEND) begin
                if (dst_hit)        xfer_count_q <= xfer_count_q + 16'd1;
                else if (timed_out) err_code_q   <= ERR_TIMEOUT;
                else                cnt_q        <= cnt_q + 1'b1;
            end
        end
    end

    assign req_ready_o  = (state == IDLE);
    assign busy_o       = (state != IDLE);
    assign done_o       = (state == DONE);
    assign err_o        = (state == ERR);
    assign err_code_o   = err_code_q;
    assign xfer_count_o = xfer_count_q;
    assign dst_valid_o  = (state == SEND) ? (4'b0001 << dest_q) : 4'b0000;
    assign demux_din    = (state == SEND) ? data_q : '0;

    DeMux4 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_demux (
        .sel  (dest_q),
        .din  (demux_din),
        .dout0(dst_data0_o),
        .dout1(dst_data1_o),
        .dout2(dst_data2_o),
        .dout3(dst_data3_o)
    );

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Self-checking bench for demux_dispatch_ctrl against a transaction-level model of the dispatcher.
module tb_demux_dispatch_ctrl;
    import dispatch_pkg::*;

    localparam int DW      = 32;
    localparam int TIMEOUT = 15;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [1:0]    req_dest_i = '0;
    logic [DW-1:0] req_data_i = '0;
    logic [3:0]    dest_en_i = '0;
    logic [3:0]    dst_valid_o;
    logic [3:0]    dst_ready_i = '0;
    logic [DW-1:0] dst_data0_o, dst_data1_o, dst_data2_o, dst_data3_o;
    logic          busy_o, done_o, err_o;
    logic [1:0]    err_code_o;
    logic [15:0]   xfer_count_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_count  = '0;
    logic [1:0]  m_code   = ERR_NONE;

    demux_dispatch_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_dest_i(req_dest_i), .req_data_i(req_data_i), .dest_en_i(dest_en_i),
        .dst_valid_o(dst_valid_o), .dst_ready_i(dst_ready_i),
        .dst_data0_o(dst_data0_o), .dst_data1_o(dst_data1_o),
        .dst_data2_o(dst_data2_o), .dst_data3_o(dst_data3_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .err_code_o(err_code_o), .xfer_count_o(xfer_count_o)
    );

    always #5 clk_i = ~clk_i;

    // One complete request: idle check, accept, SEND cycles, DONE/ERR pulse. Ends at the negedge of
    // the DONE/ERR cycle. ready_at is the SEND cycle index (0-based) where the selected ready rises;
    // a negative or out-of-window value means it never does.
    task automatic run_xfer(input logic [1:0] dest, input logic [DW-1:0] data, input logic [3:0] en,
                            input int ready_at, input logic [3:0] noise, input string tag);
        logic [3:0]      sel;
        int              send_cycles;
        logic            exp_done;
        logic [4*DW-1:0] exp_bus;
        sel = 4'b0001 << dest;
        if (!en[dest])                              send_cycles = 0;
        else if (ready_at >= 0 && ready_at < TIMEOUT) send_cycles = ready_at + 1;
        else                                        send_cycles = TIMEOUT;
        exp_done = en[dest] && (ready_at >= 0) && (ready_at < TIMEOUT);

        @(negedge clk_i);
        n_checks++;
        if ({req_ready_o, busy_o, dst_valid_o, done_o, err_o, err_code_o, xfer_count_o} !==
            {1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, m_code, m_count} ||
            {dst_data0_o, dst_data1_o, dst_data2_o, dst_data3_o} !== '0) begin
            n_fail++;
            $display("FAIL %s idle: got ready=%b busy=%b valid=%b done=%b err=%b code=%0d count=%h, want ready=1 busy=0 valid=0000 done=0 err=0 code=%0d count=%h, data zero",
                     tag, req_ready_o, busy_o, dst_valid_o, done_o, err_o, err_code_o, xfer_count_o, m_code, m_count);
        end
        req_valid_i = 1'b1;
        req_dest_i  = dest;
        req_data_i  = data;
        dest_en_i   = en;
        @(posedge clk_i);
        #1;
        // Scramble request-side inputs after accept: the transfer in flight must not notice.
        req_valid_i = 1'b0;
        req_dest_i  = 2'($urandom_range(0, 3));
        req_data_i  = $urandom;
        dest_en_i   = 4'($urandom_range(0, 15));
        m_code      = ERR_NONE;

        exp_bus = '0;
        for (int n = 0; n < 4; n++) if (sel[n]) exp_bus[(3-n)*DW +: DW] = data;

        for (int i = 0; i < send_cycles; i++) begin
            dst_ready_i = (noise & ~sel) | ((i == ready_at) ? sel : 4'b0000);
            @(negedge clk_i);
            n_checks++;
            if ({dst_valid_o, busy_o, req_ready_o, done_o, err_o, err_code_o} !==
                {sel, 1'b1, 1'b0, 1'b0, 1'b0, ERR_NONE} ||
                {dst_data0_o, dst_data1_o, dst_data2_o, dst_data3_o} !== exp_bus) begin
                n_fail++;
                $display("FAIL %s send[%0d]: got valid=%b busy=%b ready=%b done=%b err=%b code=%0d d0..3=%h %h %h %h, want valid=%b word=%h on dest %0d",
                         tag, i, dst_valid_o, busy_o, req_ready_o, done_o, err_o, err_code_o,
                         dst_data0_o, dst_data1_o, dst_data2_o, dst_data3_o, sel, data, dest);
            end
            @(posedge clk_i);
            #1;
        end

        dst_ready_i = noise;
        if (exp_done)         m_count = m_count + 16'd1;
        else if (!en[dest])   m_code  = ERR_DISABLED;
        else                  m_code  = ERR_TIMEOUT;
        @(negedge clk_i);
        n_checks++;
        if ({done_o, err_o, err_code_o, xfer_count_o, dst_valid_o, busy_o, req_ready_o} !==
            {exp_done, ~exp_done, m_code, m_count, 4'b0000, 1'b1, 1'b0} ||
            {dst_data0_o, dst_data1_o, dst_data2_o, dst_data3_o} !== '0) begin
            n_fail++;
            $display("FAIL %s end: got done=%b err=%b code=%0d count=%h valid=%b busy=%b ready=%b, want done=%b err=%b code=%0d count=%h valid=0000 busy=1 ready=0",
                     tag, done_o, err_o, err_code_o, xfer_count_o, dst_valid_o, busy_o, req_ready_o,
                     exp_done, ~exp_done, m_code, m_count);
        end
        dst_ready_i = 4'b0000;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        reset_i     = 1'b1;
        req_valid_i = 1'b1;
        dest_en_i   = 4'hF;
        dst_ready_i = 4'hF;
        @(posedge clk_i);
        @(negedge clk_i);
        m_count = '0;
        m_code  = ERR_NONE;
        n_checks++;
        if ({req_ready_o, busy_o, dst_valid_o, done_o, err_o, err_code_o, xfer_count_o} !==
            {1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 16'd0} ||
            {dst_data0_o, dst_data1_o, dst_data2_o, dst_data3_o} !== '0) begin
            n_fail++;
            $display("FAIL reset: got ready=%b busy=%b valid=%b done=%b err=%b code=%0d count=%h, want 1 0 0000 0 0 0 0000",
                     req_ready_o, busy_o, dst_valid_o, done_o, err_o, err_code_o, xfer_count_o);
        end
        reset_i     = 1'b0;
        req_valid_i = 1'b0;
        dst_ready_i = 4'b0000;
    endtask

    task automatic test_basic();
        run_xfer(2'd2, 32'hDEADBEEF, 4'hF, 0, 4'b0000, "basic");
    endtask

    task automatic test_timeout();
        run_xfer(2'd1, 32'h1234_5678, 4'hF, -1, 4'b0000, "timeout");
    endtask

    task automatic test_disabled();
        run_xfer(2'd3, 32'hCAFE_F00D, 4'b0111, 0, 4'b1111, "disabled");
        run_xfer(2'd0, 32'h0BAD_CAFE, 4'hF, 2, 4'b0000, "clear_code");
    endtask

    task automatic test_last_cycle();
        run_xfer(2'd0, 32'hA5A5_5A5A, 4'hF, TIMEOUT - 1, 4'b0010, "last_cycle");
        run_xfer(2'd2, 32'h5555_AAAA, 4'hF, TIMEOUT, 4'b1011, "one_late");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            run_xfer(2'(i), $urandom, 4'hF, 0, 4'($urandom_range(0, 15)), "back_to_back");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            run_xfer(2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, TIMEOUT + 3), 4'($urandom_range(0, 15)), "random");
    endtask

    task automatic test_reset_mid_send();
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_dest_i  = 2'd3;
        req_data_i  = 32'hFEED_0001;
        dest_en_i   = 4'hF;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        reset_i     = 1'b1;
        dst_ready_i = 4'b1000;
        @(posedge clk_i);
        @(negedge clk_i);
        m_count = '0;
        m_code  = ERR_NONE;
        n_checks++;
        if ({dst_valid_o, req_ready_o, busy_o, done_o, err_o, err_code_o, xfer_count_o} !==
            {4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0} ||
            {dst_data0_o, dst_data1_o, dst_data2_o, dst_data3_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_send: got valid=%b ready=%b busy=%b done=%b err=%b code=%0d count=%h, want 0000 1 0 0 0 0 0000",
                     dst_valid_o, req_ready_o, busy_o, done_o, err_o, err_code_o, xfer_count_o);
        end
        reset_i     = 1'b0;
        dst_ready_i = 4'b0000;
    endtask

    task automatic test_wrap();
        force dut.xfer_count_q = 16'hFFFF;
        #1;
        release dut.xfer_count_q;
        m_count = 16'hFFFF;
        run_xfer(2'd1, 32'h7777_8888, 4'hF, 1, 4'b0000, "wrap");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_disabled();
        test_last_cycle();
        test_back_to_back();
        test_random();
        test_reset_mid_send();
        test_basic();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
